rom_prefetch: RTL

ROM_PREFETCH -- requirements
Module: rom_prefetch

---
 rtl/rom_prefetch.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rom_prefetch.sv
// rom_prefetch: instruction prefetcher that streams words from a 2 KB ROM
// window into a small FIFO and presents the FIFO head to a consumer.
// The fetch stream restarts on a redirect pulse or on reset.
// Optional build macro PREFETCH_STATS_EN adds a saturating stall counter
// output (stall_cnt) that counts cycles with no valid head outside reset.
module rom_prefetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        rom_en,
   output logic [8:0]  rom_addr,
   input  logic [31:0] rom_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
`ifdef PREFETCH_STATS_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Operating mode of the current cycle: reset, normal issue, or the single
   // flush cycle in which a redirect is taken.
   typedef enum logic [1:0] {
      ST_RESET,
      ST_RUN,
      ST_FLUSH
   } mode_t;

   mode_t            mode;
   logic [31:0]      fetch_pc;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             head_vld;
   logic             push;
   logic             pop;

   logic [31:0] mem_data [DEPTH];
   logic [31:0] mem_pc   [DEPTH];

   // Mode decode: reset dominates redirect, redirect suppresses issue.
   always_comb begin
      mode = ST_RUN;
      if (rst)
         mode = ST_RESET;
      else if (redirect)
         mode = ST_FLUSH;
   end

   // Issue and handshake decode. A fetch is allowed whenever a slot is free
   // or the head leaves in the same cycle, so a full FIFO still streams.
   // inst_valid is masked by rst so no word can be consumed during reset.
   always_comb begin
      head_vld = (count != '0);
      inst_valid = head_vld && !rst;
      pop = inst_valid && inst_ready;
      push = (mode == ST_RUN) && ((count < CNT_W'(DEPTH)) || pop);
      rom_en = push;
      rom_addr = fetch_pc[10:2];
      inst = mem_data[rd_ptr];
      inst_pc = mem_pc[rd_ptr];
   end

   // Control state: pointers, occupancy and the fetch address.
   // rom_addr is a slice of fetch_pc, so it wraps 511 -> 0 on its own while
   // the full byte address keeps counting for inst_pc.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         fetch_pc <= RESET_PC;
      end else begin
         case (mode)
            ST_FLUSH: begin
               // The head taken in this cycle (if any) belongs to the
               // consumer; everything else queued is dropped.
               count <= '0;
               wr_ptr <= '0;
               rd_ptr <= '0;
               fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            end
            ST_RUN: begin
               if (push) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  fetch_pc <= fetch_pc + 32'd4;
               end
               if (pop)
                  rd_ptr <= rd_ptr + 1'b1;
               count <= count + CNT_W'(push) - CNT_W'(pop);
            end
            default: ;
         endcase
      end
   end

   // FIFO storage: the ROM word arriving at the edge that closes a rom_en
   // cycle is written together with the address it was fetched from.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= rom_data;
         mem_pc[wr_ptr] <= fetch_pc;
      end
   end

`ifdef PREFETCH_STATS_EN
   // Stall statistics: cycles without a valid head, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (!inst_valid && (stall_cnt != 32'hFFFF_FFFF))
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule
